// File: rtl/lfsr_seq_ctrl.sv
`timescale 1ns/1ps
// lfsr_seq_ctrl
// Configures, seeds and sequences a programmable Fibonacci LFSR, then streams
// a requested number of pseudo-random words over a valid/ready handshake.
// It also measures the sequence period: the number of steps taken before the
// state first returns to the seed.
//
// Ports:
//   clk, reset_n       clock (rising edge) and asynchronous active-low reset
//   cfg_valid/ready    configuration write handshake (ready only in IDLE)
//   cfg_seed/taps      initial LFSR state and tap mask (bit i => q[i] in XOR)
//   cfg_count          number of words to emit per run
//   start, abort       launch a run from IDLE / cancel a run in LOAD or RUN
//   busy, done         run in progress (LOAD/RUN) / one-cycle end-of-run pulse
//   seed_err           sticky: a zero seed was written or start had no config
//   out_valid/ready    output word handshake, out_data is the LFSR state
//   period_hit/len     one-cycle pulse and latched length of first return
module lfsr_seq_ctrl #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [N-1:0]     cfg_seed,
  input  logic [N-1:0]     cfg_taps,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             seed_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic             period_hit,
  output logic [CNT_W-1:0] period_len
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     seed_q, seed_d;
  logic [N-1:0]     taps_q, taps_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [N-1:0]     lfsr_q, lfsr_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic [CNT_W-1:0] period_len_q, period_len_d;
  logic             period_hit_q, period_hit_d;
  logic             seed_err_q, seed_err_d;

  logic             cfg_accept;
  logic             cfg_good;
  logic [N-1:0]     lfsr_next;
  logic [CNT_W-1:0] step_inc;

  // State register and all datapath registers; reset clears everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      seed_q       <= '0;
      taps_q       <= '0;
      count_q      <= '0;
      lfsr_q       <= '0;
      remaining_q  <= '0;
      step_q       <= '0;
      period_len_q <= '0;
      period_hit_q <= 1'b0;
      seed_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      seed_q       <= seed_d;
      taps_q       <= taps_d;
      count_q      <= count_d;
      lfsr_q       <= lfsr_d;
      remaining_q  <= remaining_d;
      step_q       <= step_d;
      period_len_q <= period_len_d;
      period_hit_q <= period_hit_d;
      seed_err_q   <= seed_err_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d      = state_q;
    seed_d       = seed_q;
    taps_d       = taps_q;
    count_d      = count_q;
    lfsr_d       = lfsr_q;
    remaining_d  = remaining_q;
    step_d       = step_q;
    period_len_d = period_len_q;
    period_hit_d = 1'b0;
    seed_err_d   = seed_err_q;

    cfg_accept = (state_q == IDLE) && cfg_valid;
    cfg_good   = cfg_accept && (cfg_seed != '0);
    // Right shift with the tap parity entering at the MSB.
    lfsr_next  = {^(lfsr_q & taps_q), lfsr_q[N-1:1]};
    // Saturating step count so a very long period never wraps to zero.
    step_inc   = (step_q == '1) ? step_q : step_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (cfg_accept) begin
          if (cfg_good) begin
            seed_d     = cfg_seed;
            taps_d     = cfg_taps;
            count_d    = cfg_count;
            seed_err_d = 1'b0;
          end else begin
            seed_err_d = 1'b1;
          end
        end
        // A same-cycle good write counts as a valid configuration for start.
        if (start) begin
          if (cfg_good || (seed_q != '0)) begin
            state_d = LOAD;
          end else begin
            seed_err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        lfsr_d       = seed_q;
        remaining_d  = count_q;
        step_d       = '0;
        period_len_d = '0;
        if (abort) begin
          state_d = IDLE;
        end else if (count_q == '0) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (out_ready) begin
          lfsr_d      = lfsr_next;
          remaining_d = remaining_q - CNT_W'(1);
          step_d      = step_inc;
          // Only the first return to the seed is recorded.
          if ((lfsr_next == seed_q) && (period_len_q == '0)) begin
            period_len_d = step_inc;
            period_hit_d = 1'b1;
          end
        end
        // Abort wins over completion: an aborted run never pulses done.
        if (abort) begin
          state_d = IDLE;
        end else if (out_ready && (remaining_q == CNT_W'(1))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cfg_ready  = (state_q == IDLE);
  assign busy       = (state_q == LOAD) || (state_q == RUN);
  assign done       = (state_q == DONE);
  assign out_valid  = (state_q == RUN);
  assign out_data   = lfsr_q;
  assign seed_err   = seed_err_q;
  assign period_hit = period_hit_q;
  assign period_len = period_len_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
`timescale 1ns/1ps
// tb_lfsr_seq_ctrl
// Self-checking bench for lfsr_seq_ctrl with N=3. Expected words and periods
// come from a behavioural model that steps the LFSR with plain arithmetic.
module tb_lfsr_seq_ctrl;

  localparam int N     = 3;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [N-1:0]     cfg_seed = '0;
  logic [N-1:0]     cfg_taps = '0;
  logic [CNT_W-1:0] cfg_count = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             busy;
  logic             done;
  logic             seed_err;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [N-1:0]     out_data;
  logic             period_hit;
  logic [CNT_W-1:0] period_len;

  int compared   = 0;
  int mismatched = 0;

  // Results gathered by run_stream for the calling test to judge.
  logic [N-1:0] obs_words[$];
  logic [N-1:0] exp_words[$];
  int obs_done_cycle;
  int obs_hits;
  int obs_hold_errs;
  int obs_valid_cycles;
  int obs_last_xfer;

  lfsr_seq_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_seed(cfg_seed), .cfg_taps(cfg_taps), .cfg_count(cfg_count),
    .start(start), .abort(abort), .busy(busy), .done(done),
    .seed_err(seed_err), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .period_hit(period_hit), .period_len(period_len)
  );

  always #5 clk = ~clk;

  // Behavioural model: parity of the tapped bits enters at the top.
  function automatic logic [N-1:0] ref_step(input logic [N-1:0] q, input logic [N-1:0] taps);
    int par;
    int nxt;
    par = $countones(q & taps) % 2;
    nxt = (int'(q) / 2) + par * (1 << (N - 1));
    return N'(nxt);
  endfunction

  function automatic int ref_period(input logic [N-1:0] seed, input logic [N-1:0] taps);
    logic [N-1:0] q;
    q = seed;
    for (int k = 1; k <= (1 << N) + 1; k++) begin
      q = ref_step(q, taps);
      if (q == seed) return k;
    end
    return 0;
  endfunction

  task automatic build_model(input logic [N-1:0] seed, input logic [N-1:0] taps, input int count);
    logic [N-1:0] q;
    exp_words.delete();
    q = seed;
    for (int i = 0; i < count; i++) begin
      exp_words.push_back(q);
      q = ref_step(q, taps);
    end
  endtask

  // Writes a configuration and raises start (same cycle if simultaneous).
  task automatic launch(input logic [N-1:0] seed, input logic [N-1:0] taps,
                        input int count, input bit simultaneous);
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_seed  = seed;
    cfg_taps  = taps;
    cfg_count = CNT_W'(count);
    if (!simultaneous) begin
      @(negedge clk);
      cfg_valid = 1'b0;
    end
    start = 1'b1;
  endtask

  // Drives out_ready (0: always, 1: 1,0,0 pattern, 2: random) and records
  // transfers; optionally raises abort alongside the Nth transfer.
  task automatic run_stream(input int ready_mode, input int abort_after, input int limit);
    logic stall;
    logic [N-1:0] prev;
    obs_words.delete();
    obs_done_cycle = -1; obs_hits = 0; obs_hold_errs = 0;
    obs_valid_cycles = 0; obs_last_xfer = -1;
    stall = 1'b0; prev = '0;
    for (int cyc = 1; cyc <= limit; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      cfg_valid = 1'b0;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc - 2) % 3 == 0);
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
      if (period_hit) obs_hits++;
      if (out_valid) begin
        obs_valid_cycles++;
        if (stall && out_data !== prev) obs_hold_errs++;
      end
      if (done) begin
        obs_done_cycle = cyc;
        break;
      end
      if (out_valid && out_ready) begin
        obs_words.push_back(out_data);
        obs_last_xfer = cyc;
        if (obs_words.size() == abort_after) begin
          abort = 1'b1;
          break;
        end
      end
      stall = out_valid && !out_ready;
      prev  = out_data;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    compared++; if (cfg_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_cfg_ready: got %0b, expected 1", cfg_ready); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %0b, expected 0", busy); end
    compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %0b, expected 0", done); end
    compared++; if (seed_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_seed_err: got %0b, expected 0", seed_err); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %0b, expected 0", out_valid); end
    compared++; if (out_data !== '0) begin mismatched++; $display("[TB] FAIL reset_out_data: got %0h, expected 0", out_data); end
    compared++; if (period_hit !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_period_hit: got %0b, expected 0", period_hit); end
    compared++; if (period_len !== '0) begin mismatched++; $display("[TB] FAIL reset_period_len: got %0d, expected 0", period_len); end
    reset_n = 1'b1;
    @(negedge clk);
    compared++; if (cfg_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL post_reset_cfg_ready: got %0b, expected 1", cfg_ready); end
  endtask

  task automatic test_zero_seed();
    // Start with nothing configured.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    compared++; if (seed_err !== 1'b1) begin mismatched++; $display("[TB] FAIL start_no_cfg_seed_err: got %0b, expected 1", seed_err); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL start_no_cfg_busy: got %0b, expected 0", busy); end
    // Fresh reset, then a zero-seed write followed by start.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cfg_valid = 1'b1; cfg_seed = '0; cfg_taps = 3'b011; cfg_count = 16'd4;
    @(negedge clk);
    cfg_valid = 1'b0;
    compared++; if (seed_err !== 1'b1) begin mismatched++; $display("[TB] FAIL zero_seed_err: got %0b, expected 1", seed_err); end
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_seed_busy[%0d]: got %0b, expected 0", i, busy); end
      compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_seed_out_valid[%0d]: got %0b, expected 0", i, out_valid); end
    end
    compared++; if (seed_err !== 1'b1) begin mismatched++; $display("[TB] FAIL zero_seed_sticky: got %0b, expected 1", seed_err); end
    cfg_valid = 1'b1; cfg_seed = 3'b101;
    @(negedge clk);
    cfg_valid = 1'b0;
    compared++; if (seed_err !== 1'b0) begin mismatched++; $display("[TB] FAIL seed_err_clear: got %0b, expected 0", seed_err); end
  endtask

  task automatic test_max_length();
    build_model(3'b001, 3'b011, 8);
    launch(3'b001, 3'b011, 8, 1'b0);
    run_stream(0, -1, 40);
    compared++; if (obs_words.size() !== 8) begin mismatched++; $display("[TB] FAIL maxlen_word_count: got %0d, expected 8", obs_words.size()); end
    for (int i = 0; i < exp_words.size(); i++) begin
      compared++;
      if (i >= obs_words.size() || obs_words[i] !== exp_words[i]) begin
        mismatched++;
        $display("[TB] FAIL maxlen_word[%0d]: got %0h, expected %0h", i, (i < obs_words.size()) ? obs_words[i] : 'x, exp_words[i]);
      end
    end
    compared++; if (obs_hits !== 1) begin mismatched++; $display("[TB] FAIL maxlen_hits: got %0d, expected 1", obs_hits); end
    compared++; if (period_len !== 16'd7) begin mismatched++; $display("[TB] FAIL maxlen_period_len: got %0d, expected 7", period_len); end
    compared++; if (obs_done_cycle !== 10) begin mismatched++; $display("[TB] FAIL maxlen_done_cycle: got %0d, expected 10", obs_done_cycle); end
    @(negedge clk);
    compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL maxlen_done_pulse: got %0b, expected 0", done); end
    compared++; if (cfg_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL maxlen_cfg_ready: got %0b, expected 1", cfg_ready); end
  endtask

  task automatic test_backpressure();
    build_model(3'b001, 3'b011, 8);
    launch(3'b001, 3'b011, 8, 1'b0);
    run_stream(1, -1, 60);
    compared++; if (obs_words.size() !== 8) begin mismatched++; $display("[TB] FAIL bp_word_count: got %0d, expected 8", obs_words.size()); end
    for (int i = 0; i < exp_words.size(); i++) begin
      compared++;
      if (i >= obs_words.size() || obs_words[i] !== exp_words[i]) begin
        mismatched++;
        $display("[TB] FAIL bp_word[%0d]: got %0h, expected %0h", i, (i < obs_words.size()) ? obs_words[i] : 'x, exp_words[i]);
      end
    end
    compared++; if (obs_hold_errs !== 0) begin mismatched++; $display("[TB] FAIL bp_hold: got %0d changes, expected 0", obs_hold_errs); end
    compared++; if (obs_valid_cycles !== 22) begin mismatched++; $display("[TB] FAIL bp_valid_cycles: got %0d, expected 22", obs_valid_cycles); end
    compared++; if (obs_done_cycle !== 24) begin mismatched++; $display("[TB] FAIL bp_done_cycle: got %0d, expected 24", obs_done_cycle); end
    compared++; if (obs_hits !== 1) begin mismatched++; $display("[TB] FAIL bp_hits: got %0d, expected 1", obs_hits); end
    compared++; if (period_len !== 16'd7) begin mismatched++; $display("[TB] FAIL bp_period_len: got %0d, expected 7", period_len); end
  endtask

  task automatic test_count_zero();
    launch(3'b101, 3'b011, 0, 1'b0);
    run_stream(0, -1, 10);
    compared++; if (obs_done_cycle !== 2) begin mismatched++; $display("[TB] FAIL cnt0_done_cycle: got %0d, expected 2", obs_done_cycle); end
    compared++; if (obs_valid_cycles !== 0) begin mismatched++; $display("[TB] FAIL cnt0_valid_cycles: got %0d, expected 0", obs_valid_cycles); end
  endtask

  task automatic test_abort();
    int done_seen;
    launch(3'b001, 3'b011, 8, 1'b0);
    run_stream(0, 3, 20);
    @(negedge clk);
    abort = 1'b0;
    compared++; if (obs_words.size() !== 3) begin mismatched++; $display("[TB] FAIL abort_words: got %0d, expected 3", obs_words.size()); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_out_valid: got %0b, expected 0", out_valid); end
    compared++; if (cfg_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_cfg_ready: got %0b, expected 1", cfg_ready); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_busy: got %0b, expected 0", busy); end
    compared++; if (out_data !== 3'b101) begin mismatched++; $display("[TB] FAIL abort_last_state: got %0h, expected 5", out_data); end
    done_seen = (done === 1'b1) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    compared++; if (done_seen !== 0) begin mismatched++; $display("[TB] FAIL abort_no_done: got %0d pulses, expected 0", done_seen); end
  endtask

  task automatic test_reset_mid_run();
    launch(3'b001, 3'b011, 20, 1'b0);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      start = 1'b0;
      cfg_valid = 1'b0;
      out_ready = 1'b1;
    end
    compared++; if (period_len !== 16'd7) begin mismatched++; $display("[TB] FAIL midrun_period_len: got %0d, expected 7", period_len); end
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL midrun_out_valid: got %0b, expected 1", out_valid); end
    #2 reset_n = 1'b0;
    #1;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL async_out_valid: got %0b, expected 0", out_valid); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL async_busy: got %0b, expected 0", busy); end
    compared++; if (out_data !== '0) begin mismatched++; $display("[TB] FAIL async_out_data: got %0h, expected 0", out_data); end
    compared++; if (period_len !== '0) begin mismatched++; $display("[TB] FAIL async_period_len: got %0d, expected 0", period_len); end
    compared++; if (cfg_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL async_cfg_ready: got %0b, expected 1", cfg_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    build_model(3'b110, 3'b011, 2);
    launch(3'b110, 3'b011, 2, 1'b1);
    run_stream(0, -1, 10);
    compared++; if (obs_words.size() !== 2) begin mismatched++; $display("[TB] FAIL simul_word_count: got %0d, expected 2", obs_words.size()); end
    for (int i = 0; i < exp_words.size(); i++) begin
      compared++;
      if (i >= obs_words.size() || obs_words[i] !== exp_words[i]) begin
        mismatched++;
        $display("[TB] FAIL simul_word[%0d]: got %0h, expected %0h", i, (i < obs_words.size()) ? obs_words[i] : 'x, exp_words[i]);
      end
    end
    compared++; if (obs_done_cycle !== 4) begin mismatched++; $display("[TB] FAIL simul_done_cycle: got %0d, expected 4", obs_done_cycle); end
  endtask

  task automatic test_random();
    logic [N-1:0] seed, taps;
    int count, per, exp_hits, exp_done;
    for (int it = 0; it < 8; it++) begin
      seed  = N'($urandom_range(1, (1 << N) - 1));
      taps  = N'($urandom_range(0, (1 << N) - 1));
      count = $urandom_range(0, 20);
      build_model(seed, taps, count);
      per = ref_period(seed, taps);
      exp_hits = (per != 0 && per <= count) ? 1 : 0;
      launch(seed, taps, count, $urandom_range(0, 1) == 1);
      run_stream(2, -1, 200);
      exp_done = (count == 0) ? 2 : obs_last_xfer + 1;
      compared++; if (obs_words.size() !== count) begin mismatched++; $display("[TB] FAIL rand%0d_word_count: got %0d, expected %0d", it, obs_words.size(), count); end
      for (int i = 0; i < exp_words.size(); i++) begin
        compared++;
        if (i >= obs_words.size() || obs_words[i] !== exp_words[i]) begin
          mismatched++;
          $display("[TB] FAIL rand%0d_word[%0d]: got %0h, expected %0h", it, i, (i < obs_words.size()) ? obs_words[i] : 'x, exp_words[i]);
        end
      end
      compared++; if (obs_hits !== exp_hits) begin mismatched++; $display("[TB] FAIL rand%0d_hits: got %0d, expected %0d", it, obs_hits, exp_hits); end
      compared++; if (period_len !== CNT_W'(exp_hits ? per : 0)) begin mismatched++; $display("[TB] FAIL rand%0d_period_len: got %0d, expected %0d", it, period_len, exp_hits ? per : 0); end
      compared++; if (obs_hold_errs !== 0) begin mismatched++; $display("[TB] FAIL rand%0d_hold: got %0d changes, expected 0", it, obs_hold_errs); end
      compared++; if (obs_done_cycle !== exp_done || obs_done_cycle < 0) begin mismatched++; $display("[TB] FAIL rand%0d_done_cycle: got %0d, expected %0d", it, obs_done_cycle, exp_done); end
    end
  endtask

  initial begin
    test_reset();
    test_zero_seed();
    test_max_length();
    test_backpressure();
    test_count_zero();
    test_abort();
    test_reset_mid_run();
    test_simultaneous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
